// File: rtl/td4_pkg.sv
// Shared TD4 definitions: program memory geometry, frame marker and the state
// encodings used by the serial program loader and its UART receiver.
package td4_pkg;
  localparam int PROG_DEPTH = 16;
  localparam int INSTR_W    = 8;
  localparam int ADDR_W     = $clog2(PROG_DEPTH);

  localparam logic [INSTR_W-1:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CHECK, ST_DONE} loader_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/td4_prog_loader_if.sv
// Instruction-memory write port driven by the program loader.
interface td4_prog_loader_if;
  import td4_pkg::*;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/td4_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting
// start detection; pulses byte_valid on a good stop bit, frame_err otherwise.
module td4_uart_rx
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n;
  logic             valid_n, err_n;
  logic             rx_meta, rx_sync, rx_prev;

  // NOTE: synchroniser flops reset to the idle-high line level so that leaving
  // reset never looks like a falling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      byte_valid <= valid_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shift_n = shift;
    valid_n = 1'b0;
    err_n   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      RX_START: if (cnt == HALF) begin
        // A start bit that is high again at mid-bit was only a glitch.
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_sync ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == FULL) begin
        cnt_n   = '0;
        shift_n = {rx_sync, shift[7:1]};
        bit_n   = bit_idx + 1'b1;
        if (bit_idx == 3'd7) state_n = RX_STOP;
      end
      RX_STOP: if (cnt == FULL) begin
        cnt_n   = '0;
        state_n = RX_IDLE;
        valid_n = rx_sync;
        err_n   = !rx_sync;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign byte_data = shift;
endmodule

// File: rtl/td4_prog_loader.sv
// TD4 serial program loader: writes a 16-byte image received over UART and
// holds the core in reset until a complete image is accepted.
// Optional checksum byte after the image: define TD4_LOADER_CHECKSUM_EN.
module td4_prog_loader
  import td4_pkg::*;
#(
  parameter int                 CLKS_PER_BIT = 434,
  parameter logic [INSTR_W-1:0] SYNC_BYTE    = SYNC_BYTE_DEF,
  parameter int                 TIMEOUT_CLKS = 5_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rx,
  td4_prog_loader_if.master       mem,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_err
);
  localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(PROG_DEPTH - 1);

  logic               byte_valid, frame_err;
  logic [INSTR_W-1:0] byte_data;

  td4_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  loader_state_t      state, state_n;
  logic [ADDR_W-1:0]  idx, idx_n, addr_q, addr_n;
  logic [INSTR_W-1:0] sum, sum_n, wdata_q, wdata_n;
  logic [TMO_W-1:0]   tmo_cnt, tmo_n;
  logic               we_q, we_n, hold_n, done_n, err_n;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the values from before this edge, whatever order the tools evaluate in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      sum       <= '0;
      tmo_cnt   <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sum       <= sum_n;
      tmo_cnt   <= tmo_n;
      we_q      <= we_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      cpu_hold  <= hold_n;
      load_done <= done_n;
      load_err  <= err_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sum_n   = sum;
    tmo_n   = '0;
    we_n    = 1'b0;
    addr_n  = addr_q;
    wdata_n = wdata_q;
    hold_n  = cpu_hold;
    done_n  = load_done;
    err_n   = load_err;
    case (state)
      ST_IDLE: if (byte_valid && byte_data == SYNC_BYTE) begin
        state_n = ST_LOAD;
        hold_n  = 1'b1;
        done_n  = 1'b0;
        err_n   = 1'b0;
        idx_n   = '0;
        sum_n   = '0;
      end
      ST_LOAD, ST_CHECK: begin
        // Any abort keeps the core held: a partial image must never run.
        if (frame_err || (!byte_valid && tmo_cnt == TMO_LAST)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else if (byte_valid) begin
          if (state == ST_LOAD) begin
            we_n    = 1'b1;
            addr_n  = idx;
            wdata_n = byte_data;
            sum_n   = sum + byte_data;
            if (idx == IDX_LAST) begin
`ifdef TD4_LOADER_CHECKSUM_EN
              state_n = ST_CHECK;
`else
              state_n = ST_DONE;
              hold_n  = 1'b0;
              done_n  = 1'b1;
`endif
            end else begin
              idx_n = idx + 1'b1;
            end
          end
`ifdef TD4_LOADER_CHECKSUM_EN
          else if (byte_data == sum) begin
            state_n = ST_DONE;
            hold_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
          end
`endif
        end else begin
          tmo_n = tmo_cnt + 1'b1;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_td4_prog_loader.sv
// Directed bench for td4_prog_loader: good frames, bad checksum, timeout,
// framing error, start-bit glitch and mid-frame reset.
module tb_td4_prog_loader;
  import td4_pkg::*;

  localparam int CPB = 16;
  localparam int TMO = 2000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic cpu_hold, load_done, load_err;

  td4_prog_loader_if mem_if ();

  td4_prog_loader #(
    .CLKS_PER_BIT (CPB),
    .SYNC_BYTE    (8'hA5),
    .TIMEOUT_CLKS (TMO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .mem       (mem_if),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] prog    [16];
  logic [7:0] wr_data [16];
  bit         wr_seen [16];
  int         wr_cnt  = 0;
  int         bv_cnt  = 0;
  int         lat_err = 0;
  bit         bv_q    = 1'b0;
  logic       hold_q  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Write log and latency monitor, sampled away from the active edge.
  always @(negedge clock) begin
    if (mem_if.mem_we === 1'b1) begin
      if (!bv_q) lat_err++;
      wr_cnt++;
      wr_seen[mem_if.mem_addr] = 1'b1;
      wr_data[mem_if.mem_addr] = mem_if.mem_wdata;
    end
    if (hold_q === 1'b1 && cpu_hold === 1'b0 && reset && !bv_q) lat_err++;
    bv_q   = dut.byte_valid;
    if (dut.byte_valid) bv_cnt++;
    hold_q = cpu_hold;
  end

  task automatic clear_log();
    wr_cnt  = 0;
    lat_err = 0;
    for (int i = 0; i < 16; i++) begin
      wr_seen[i] = 1'b0;
      wr_data[i] = 8'h00;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clock);
    rx = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic send_frame(input bit good_sum);
    logic [7:0] s;
    s = 8'h00;
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send_byte(prog[i], 1'b1);
      s = s + prog[i];
    end
`ifdef TD4_LOADER_CHECKSUM_EN
    send_byte(good_sum ? s : s + 8'h01, 1'b1);
`else
    if (!good_sum) s = 8'h00;
`endif
    repeat (20) @(negedge clock);
  endtask

  task automatic check_image(input string tag);
    check({tag, "_wr_cnt"}, wr_cnt, 16);
    check({tag, "_latency"}, lat_err, 0);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_addr%0d", tag, i), {wr_seen[i], wr_data[i]}, {1'b1, prog[i]});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_we"},    mem_if.mem_we,    0);
    check({tag, "_mem_addr"},  mem_if.mem_addr,  0);
    check({tag, "_mem_wdata"}, mem_if.mem_wdata, 0);
    check({tag, "_cpu_hold"},  cpu_hold,         0);
    check({tag, "_load_done"}, load_done,        0);
    check({tag, "_load_err"},  load_err,         0);
  endtask

  initial begin
    int bv0;
    clear_log();

    // 1. reset and long idle
    repeat (5) @(negedge clock);
    check_outputs_zero("in_reset");
    reset = 1'b1;
    repeat (10000) @(negedge clock);
    check_outputs_zero("idle");
    check("idle_no_writes", wr_cnt, 0);

    // 2. good frame
    prog = '{8'h3C, 8'h36, 8'h73, 8'h79, 8'h00, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    clear_log();
    fork
      send_frame(1'b1);
      begin
        repeat (CPB * 10 * 3) @(negedge clock);
        check("hold_during_load", cpu_hold, 1);
        check("done_during_load", load_done, 0);
      end
    join
    check_image("frame1");
    check("frame1_hold", cpu_hold, 0);
    check("frame1_done", load_done, 1);
    check("frame1_err", load_err, 0);
    check("frame1_last_addr", mem_if.mem_addr, 15);

`ifdef TD4_LOADER_CHECKSUM_EN
    // 3. bad checksum, then good frame
    clear_log();
    send_frame(1'b0);
    check("badsum_err", load_err, 1);
    check("badsum_hold", cpu_hold, 1);
    check("badsum_done", load_done, 0);
    clear_log();
    send_frame(1'b1);
    check_image("resend");
    check("resend_err", load_err, 0);
    check("resend_done", load_done, 1);
`endif

    // Sync byte inside the image is plain data
    prog = '{8'hA5, 8'h12, 8'hA5, 8'hFF, 8'h80, 8'h01, 8'h5A, 8'hC3,
             8'h9B, 8'h44, 8'h27, 8'hE0, 8'h0F, 8'hA5, 8'h7E, 8'hB1};
    clear_log();
    send_frame(1'b1);
    check_image("syncdata");
    check("syncdata_done", load_done, 1);

    // 4. timeout after 5 data bytes
    clear_log();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(prog[i], 1'b1);
    repeat (TMO + 500) @(negedge clock);
    check("tmo_err", load_err, 1);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_done", load_done, 0);
    check("tmo_writes", wr_cnt, 5);
    prog = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
             8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hF0, 8'h0E};
    clear_log();
    send_frame(1'b1);
    check_image("after_tmo");
    check("after_tmo_err", load_err, 0);
    check("after_tmo_hold", cpu_hold, 0);

    // 5. framing error on byte index 7
    clear_log();
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 7; i++) send_byte(prog[i], 1'b1);
    send_byte(prog[7], 1'b0);
    repeat (20) @(negedge clock);
    check("frame_err_err", load_err, 1);
    check("frame_err_hold", cpu_hold, 1);
    check("frame_err_no_addr7", wr_seen[7], 0);
    check("frame_err_writes", wr_cnt, 7);

    // 6. start-bit glitch in IDLE
    bv0 = bv_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rx = 1'b1;
    repeat (CPB * 12) @(negedge clock);
    check("glitch_no_byte", bv_cnt - bv0, 0);
    check("glitch_err_kept", load_err, 1);

    // Reset in the middle of byte index 9
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) send_byte(prog[i], 1'b1);
    rx = 1'b0;
    repeat (CPB * 3) @(negedge clock);
    check("pre_reset_hold", cpu_hold, 1);
    reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    rx = 1'b1;
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (CPB * 12) @(negedge clock);
    check_outputs_zero("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
